id_ex_buffer: RTL and testbench

//  Decode->execute pipeline boundary. Captures the decoded bundle (pc, raw instr, 64-bit sign-extended

---
 rtl/id_ex_buffer.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_buffer.sv
// Decode->execute pipeline register with valid/ready handshake, flush and saturating stall counter.
// Define ID_EX_SKID_EN for a 2-entry skid buffer with registered in_ready; otherwise a single entry.
module id_ex_buffer #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [63:0]       in_imm,
    input  logic [4:0]        in_rd,
    input  logic [63:0]       in_rs1_data,
    input  logic [63:0]       in_rs2_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [63:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic [63:0]       out_rs1_data,
    output logic [63:0]       out_rs2_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic [63:0]       pc;
        logic [31:0]       instr;
        logic [63:0]       imm;
        logic [4:0]        rd;
        logic [63:0]       rs1_data;
        logic [63:0]       rs2_data;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t head_q;
    logic    out_valid_q;
    logic    enq;
    logic    deq;

    assign in_bundle = '{pc: in_pc, instr: in_instr, imm: in_imm, rd: in_rd,
                         rs1_data: in_rs1_data, rs2_data: in_rs2_data, ctrl: in_ctrl};
    assign deq       = out_valid_q && out_ready;

`ifdef ID_EX_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t  state_q;
    bundle_t tail_q;
    logic    in_ready_q;

    assign in_ready = in_ready_q;
    assign enq      = in_valid && in_ready_q;

    // head_q always feeds EX; tail_q only holds the entry that arrived while EX was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        head_q      <= in_bundle;
                        state_q     <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (enq && !deq) begin
                        tail_q     <= in_bundle;
                        state_q    <= S_TWO;
                        in_ready_q <= 1'b0;
                    end else if (deq && !enq) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (enq && deq) begin
                        head_q <= in_bundle;
                    end
                end
                S_TWO: begin
                    if (deq) begin
                        head_q     <= tail_q;
                        state_q    <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t state_q;

    // Accepting while full is only allowed when EX drains the entry in the same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign enq      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        head_q      <= in_bundle;
                        state_q     <= S_FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (enq) begin
                        head_q <= in_bundle;
                    end else if (deq) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturates rather than wraps so long stalls never read as short ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = head_q.pc;
    assign out_instr    = head_q.instr;
    assign out_imm      = head_q.imm;
    assign out_rd       = head_q.rd;
    assign out_rs1_data = head_q.rs1_data;
    assign out_rs2_data = head_q.rs2_data;
    assign out_ctrl     = head_q.ctrl;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_buffer.sv
// Self-checking bench for id_ex_buffer: queue model checked every cycle plus directed literal checks.
// Works in both builds; ID_EX_SKID_EN selects the expected capacity.
module tb_id_ex_buffer;
    localparam int CTRL_W = 16;
`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [63:0]       pc;
        logic [31:0]       instr;
        logic [63:0]       imm;
        logic [4:0]        rd;
        logic [63:0]       rs1_data;
        logic [63:0]       rs2_data;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    logic    clk       = 1'b0;
    logic    rst_n     = 1'b0;
    logic    flush     = 1'b0;
    logic    in_valid  = 1'b0;
    logic    out_ready = 1'b0;
    bundle_t in_b      = '0;

    logic              in_ready, out_valid;
    logic [63:0]       out_pc, out_imm, out_rs1_data, out_rs2_data;
    logic [31:0]       out_instr;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       stall_cnt;

    logic              s_in_ready, s_out_valid;
    logic [63:0]       s_out_pc, s_out_imm, s_out_rs1_data, s_out_rs2_data;
    logic [31:0]       s_out_instr;
    logic [4:0]        s_out_rd;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [3:0]        s_stall_cnt;

    bundle_t dut_b, sat_b;
    assign dut_b = {out_pc, out_instr, out_imm, out_rd, out_rs1_data, out_rs2_data, out_ctrl};
    assign sat_b = {s_out_pc, s_out_instr, s_out_imm, s_out_rd, s_out_rs1_data, s_out_rs2_data, s_out_ctrl};

    always #5 clk = ~clk;

    id_ex_buffer #(.CTRL_W(CTRL_W), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_b.pc), .in_instr(in_b.instr), .in_imm(in_b.imm), .in_rd(in_b.rd),
        .in_rs1_data(in_b.rs1_data), .in_rs2_data(in_b.rs2_data), .in_ctrl(in_b.ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm), .out_rd(out_rd),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used to observe saturation.
    id_ex_buffer #(.CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_b.pc), .in_instr(in_b.instr), .in_imm(in_b.imm), .in_rd(in_b.rd),
        .in_rs1_data(in_b.rs1_data), .in_rs2_data(in_b.rs2_data), .in_ctrl(in_b.ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_instr(s_out_instr), .out_imm(s_out_imm), .out_rd(s_out_rd),
        .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered queue of at most CAP bundles plus an unbounded stall tally.
    bundle_t mq[$];
    int      m_stall = 0;

    function automatic logic exp_in_ready();
`ifdef ID_EX_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
        end else begin
            automatic logic m_ov = mq.size() > 0;
            automatic logic m_ir = exp_in_ready();
            if (m_ov && !out_ready) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_ov && out_ready) void'(mq.pop_front());
                if (in_valid && m_ir) mq.push_back(in_b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, mq.size() > 0);
            check("in_ready", in_ready, exp_in_ready());
            check("stall_cnt", stall_cnt, m_stall);
            check("sat_out_valid", s_out_valid, mq.size() > 0);
            check("sat_in_ready", s_in_ready, exp_in_ready());
            check("sat_stall_cnt", s_stall_cnt, (m_stall > 15) ? 15 : m_stall);
            if (mq.size() > 0) begin
                check("head_bundle", dut_b, mq[0]);
                check("sat_head_bundle", sat_b, mq[0]);
            end
        end
    end

    function automatic bundle_t mk(input int k);
        bundle_t b;
        b.pc       = 64'h8000_0000 + 64'(4 * k);
        b.instr    = 32'h0000_0013 + 32'(k << 7);
        b.imm      = 64'(k);
        b.rd       = 5'(k);
        b.rs1_data = 64'h1111_0000 + 64'(k);
        b.rs2_data = 64'h2222_0000 + 64'(k);
        b.ctrl     = 16'hC000 + 16'(k);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bundle_t rb[20];
    int      idx, nout;
    bundle_t b_a, b_d;

    initial begin
        // Test 1: asynchronous reset in the middle of a stalled stream.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_b     = mk(k);
            tick();
        end
        rst_n = 1'b0;
        #2;
        check("t1_out_valid", out_valid, 1'b0);
        check("t1_in_ready", in_ready, 1'b1);
        check("t1_stall_cnt", stall_cnt, 32'd0);
        check("t1_out_pc", out_pc, 64'd0);
        check("t1_out_imm", out_imm, 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Test 2: 8 back-to-back bundles, EX always ready.
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            in_valid = (k < 8);
            in_b     = (k < 8) ? mk(k) : '0;
            @(negedge clk);
            if (k == 0) begin
                check("t2_empty_before_accept", out_valid, 1'b0);
            end else begin
                check("t2_valid", out_valid, 1'b1);
                check("t2_pc", out_pc, 64'h8000_0000 + 64'(4 * (k - 1)));
            end
            tick();
        end

        // Test 3: negative immediate held under 5 cycles of backpressure.
        do_reset();
        b_a     = mk(40);
        b_a.imm = 64'hFFFF_FFFF_FFFF_F800;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_b      = b_a;
        tick();
        in_b = mk(41);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_imm_stable", out_imm, 64'hFFFF_FFFF_FFFF_F800);
            tick();
        end
        @(negedge clk);
        check("t3_stall_cnt", stall_cnt, 32'd5);
        check("t3_imm", out_imm, 64'hFFFF_FFFF_FFFF_F800);
        check("t3_in_ready_full", in_ready, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Test 4: flush with the buffer full and a bundle offered in the same cycle.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) begin
            in_valid = 1'b1;
            in_b     = mk(20 + k);
            tick();
        end
        b_d       = mk(60);
        b_d.pc    = 64'hDEAD_0000;
        in_b      = b_d;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_after_flush", out_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check("t4_dropped_never_seen", out_valid && (out_pc == 64'hDEAD_0000), 1'b0);
        end
        tick();

        // Test 5: random bundles with out_ready toggling every cycle, scoreboarded.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            rb[k]          = mk(100 + k);
            rb[k].pc       = {$urandom, $urandom};
            rb[k].imm      = {$urandom, $urandom};
            rb[k].rs1_data = {$urandom, $urandom};
        end
        idx  = 0;
        nout = 0;
        for (int cyc = 0; cyc < 400 && nout < 20; cyc++) begin
            in_valid  = (idx < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_b      = (idx < 20) ? rb[idx] : '0;
            out_ready = cyc[0];
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (nout < 20) check("t5_order", dut_b, rb[nout]);
                nout++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        check("t5_out_count", nout, 20);
        check("t5_in_count", idx, 20);

        // Test 6: 20 stall cycles saturate the 4-bit counter; flush does not clear it.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_b      = mk(7);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("t6_sat_cnt", s_stall_cnt, 4'd15);
        check("t6_wide_cnt", stall_cnt, 32'd20);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_sat_after_flush", s_stall_cnt, 4'd15);
        check("t6_valid_after_flush", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
